// File: rtl/ds_operand_fwd_stage.sv
// Decode-stage operand collector: holds one instruction, bypasses from NFWD producers, stalls on load-use.
// Optional DS_STALL_CNT_EN adds a stall cycle counter and per-source load-use event pulses.
module ds_operand_fwd_stage #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int NFWD       = 3,
    parameter int PAYLOAD_WD = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   ds_allowin,
    input  logic [PAYLOAD_WD-1:0]  in_payload,
    input  logic                   in_src1_en,
    input  logic [AW-1:0]          in_src1_addr,
    input  logic                   in_src2_en,
    input  logic [AW-1:0]          in_src2_addr,
    output logic [AW-1:0]          rf_raddr1,
    output logic [AW-1:0]          rf_raddr2,
    input  logic [XLEN-1:0]        rf_rdata1,
    input  logic [XLEN-1:0]        rf_rdata2,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_dest,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic                   es_allowin,
    output logic                   ds_to_es_valid,
    output logic [PAYLOAD_WD-1:0]  out_payload,
    output logic [XLEN-1:0]        out_src1,
    output logic [XLEN-1:0]        out_src2
`ifdef DS_STALL_CNT_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [1:0]             load_use_evt
`endif
);

    logic                  ds_valid_q, ds_valid_d;
    logic [PAYLOAD_WD-1:0] payload_q, payload_d;
    logic                  src1_en_q, src1_en_d;
    logic [AW-1:0]         src1_addr_q, src1_addr_d;
    logic                  src2_en_q, src2_en_d;
    logic [AW-1:0]         src2_addr_q, src2_addr_d;

    logic                  src_en   [2];
    logic [AW-1:0]         src_addr [2];
    logic [XLEN-1:0]       rf_data  [2];
    logic [XLEN-1:0]       src_val  [2];
    logic [1:0]            src_pend;
    logic                  stall;
    logic                  ds_ready_go;

    assign src_en[0]   = src1_en_q;
    assign src_en[1]   = src2_en_q;
    assign src_addr[0] = src1_addr_q;
    assign src_addr[1] = src2_addr_q;
    assign rf_data[0]  = rf_rdata1;
    assign rf_data[1]  = rf_rdata2;

    // Scan oldest to youngest so the youngest hit's value and readiness are the last ones written.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_val[s]  = '0;
            src_pend[s] = 1'b0;
            if (src_en[s] && (src_addr[s] != '0)) begin
                src_val[s] = rf_data[s];
                for (int i = NFWD - 1; i >= 0; i--) begin
                    if (fwd_valid[i] && fwd_we[i] && (fwd_dest[i*AW +: AW] == src_addr[s])) begin
                        src_val[s]  = fwd_data[i*XLEN +: XLEN];
                        src_pend[s] = ~fwd_ready[i];
                    end
                end
            end
        end
    end

    assign stall          = ds_valid_q & (|src_pend);
    assign ds_ready_go    = ~stall;
    assign ds_allowin     = ~ds_valid_q | (ds_ready_go & es_allowin);
    assign ds_to_es_valid = ds_valid_q & ds_ready_go & ~flush;

    assign rf_raddr1   = src1_addr_q;
    assign rf_raddr2   = src2_addr_q;
    assign out_payload = payload_q;
    assign out_src1    = src_val[0];
    assign out_src2    = src_val[1];

    // Flush wins over capture; the fields still load on an accepted beat so the register stays coherent.
    always_comb begin
        ds_valid_d  = ds_valid_q;
        payload_d   = payload_q;
        src1_en_d   = src1_en_q;
        src1_addr_d = src1_addr_q;
        src2_en_d   = src2_en_q;
        src2_addr_d = src2_addr_q;
        if (flush) begin
            ds_valid_d = 1'b0;
        end else if (ds_allowin) begin
            ds_valid_d = in_valid;
        end
        if (in_valid && ds_allowin) begin
            payload_d   = in_payload;
            src1_en_d   = in_src1_en;
            src1_addr_d = in_src1_addr;
            src2_en_d   = in_src2_en;
            src2_addr_d = in_src2_addr;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q  <= 1'b0;
            payload_q   <= '0;
            src1_en_q   <= 1'b0;
            src1_addr_q <= '0;
            src2_en_q   <= 1'b0;
            src2_addr_q <= '0;
        end else begin
            ds_valid_q  <= ds_valid_d;
            payload_q   <= payload_d;
            src1_en_q   <= src1_en_d;
            src1_addr_q <= src1_addr_d;
            src2_en_q   <= src2_en_d;
            src2_addr_q <= src2_addr_d;
        end
    end

`ifdef DS_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  stall_seen_q, stall_seen_d;
    logic [1:0]  src_stalling;

    assign src_stalling = {2{ds_valid_q}} & src_pend;

    // stall_seen remembers which sources this instruction already stalled on; a new capture clears it.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        stall_seen_d = stall_seen_q;
        if (stall && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (ds_allowin) begin
            stall_seen_d = 2'b00;
        end else begin
            stall_seen_d = stall_seen_q | src_stalling;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q  <= '0;
            stall_seen_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign load_use_evt = src_stalling & ~stall_seen_q;
`endif

endmodule

// File: tb/tb_ds_operand_fwd_stage.sv
// Self-checking bench for ds_operand_fwd_stage: directed scenarios plus random traffic vs. a reference model.
module tb_ds_operand_fwd_stage;

    localparam int XLEN       = 32;
    localparam int AW         = 5;
    localparam int NFWD       = 3;
    localparam int PAYLOAD_WD = 64;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  flush;
    logic                  in_valid;
    logic                  ds_allowin;
    logic [PAYLOAD_WD-1:0] in_payload;
    logic                  in_src1_en, in_src2_en;
    logic [AW-1:0]         in_src1_addr, in_src2_addr;
    logic [AW-1:0]         rf_raddr1, rf_raddr2;
    logic [XLEN-1:0]       rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]       fwd_valid, fwd_we, fwd_ready;
    logic [NFWD*AW-1:0]    fwd_dest;
    logic [NFWD*XLEN-1:0]  fwd_data;
    logic                  es_allowin;
    logic                  ds_to_es_valid;
    logic [PAYLOAD_WD-1:0] out_payload;
    logic [XLEN-1:0]       out_src1, out_src2;
`ifdef DS_STALL_CNT_EN
    logic [31:0]           stall_cnt;
    logic [1:0]            load_use_evt;
`endif

    logic [XLEN-1:0] rf_mem [32];
    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    always #5 clk = ~clk;

    ds_operand_fwd_stage #(
        .XLEN(XLEN), .AW(AW), .NFWD(NFWD), .PAYLOAD_WD(PAYLOAD_WD)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid),
        .ds_allowin(ds_allowin), .in_payload(in_payload),
        .in_src1_en(in_src1_en), .in_src1_addr(in_src1_addr),
        .in_src2_en(in_src2_en), .in_src2_addr(in_src2_addr),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_we(fwd_we), .fwd_dest(fwd_dest),
        .fwd_data(fwd_data), .fwd_ready(fwd_ready),
        .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
        .out_payload(out_payload), .out_src1(out_src1), .out_src2(out_src2)
`ifdef DS_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .load_use_evt(load_use_evt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction currently held, as plain fields.
    logic                  m_valid;
    logic [PAYLOAD_WD-1:0] m_payload;
    logic                  m_en1, m_en2;
    logic [AW-1:0]         m_addr1, m_addr2;
    logic [31:0]           m_cnt;
    logic [1:0]            m_seen;
    logic                  cur_stall, cur_allow;
    logic                  cur_p1, cur_p2;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_valid   = 1'b0;
        m_payload = '0;
        m_en1     = 1'b0;
        m_en2     = 1'b0;
        m_addr1   = '0;
        m_addr2   = '0;
        m_cnt     = '0;
        m_seen    = '0;
    endtask

    // Youngest matching producer decides; no match falls back to the register file.
    task automatic m_resolve(input logic en, input logic [AW-1:0] addr,
                             output logic [XLEN-1:0] val, output logic pend);
        val  = '0;
        pend = 1'b0;
        if (en && addr != 0) begin
            val = rf_mem[addr];
            for (int i = 0; i < NFWD; i++) begin
                if (fwd_valid[i] && fwd_we[i] && fwd_dest[i*AW +: AW] == addr) begin
                    val  = fwd_data[i*XLEN +: XLEN];
                    pend = !fwd_ready[i];
                    break;
                end
            end
        end
    endtask

    task automatic check_cycle();
        logic [XLEN-1:0] v1, v2;
        logic            p1, p2, exp_out;
        @(negedge clk);
        m_resolve(m_en1, m_addr1, v1, p1);
        m_resolve(m_en2, m_addr2, v2, p2);
        cur_p1    = p1;
        cur_p2    = p2;
        cur_stall = m_valid && (p1 || p2);
        cur_allow = !m_valid || (!cur_stall && es_allowin);
        exp_out   = m_valid && !cur_stall && !flush;
        checkOutput("allowin", 64'(ds_allowin), 64'(cur_allow));
        checkOutput("to_es_valid", 64'(ds_to_es_valid), 64'(exp_out));
        checkOutput("payload", out_payload, m_payload);
        checkOutput("raddr1", 64'(rf_raddr1), 64'(m_addr1));
        checkOutput("raddr2", 64'(rf_raddr2), 64'(m_addr2));
        if (exp_out) begin
            checkOutput("src1", 64'(out_src1), 64'(v1));
            checkOutput("src2", 64'(out_src2), 64'(v2));
        end
`ifdef DS_STALL_CNT_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        checkOutput("load_use_evt", 64'(load_use_evt),
                    64'({m_valid && p2 && !m_seen[1], m_valid && p1 && !m_seen[0]}));
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (m_valid && cur_stall && !flush) m_cnt = m_cnt + 1;
        if (cur_allow) m_seen = 2'b00;
        else           m_seen = m_seen | {m_valid && cur_p2, m_valid && cur_p1};
        if (in_valid && cur_allow) begin
            m_payload = in_payload;
            m_en1     = in_src1_en;
            m_addr1   = in_src1_addr;
            m_en2     = in_src2_en;
            m_addr2   = in_src2_addr;
        end
        if (flush)          m_valid = 1'b0;
        else if (cur_allow) m_valid = in_valid;
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [PAYLOAD_WD-1:0] pl,
                                 input logic e1, input logic [AW-1:0] a1,
                                 input logic e2, input logic [AW-1:0] a2,
                                 input logic esa, input logic fl);
        in_valid     = iv;
        in_payload   = pl;
        in_src1_en   = e1;
        in_src1_addr = a1;
        in_src2_en   = e2;
        in_src2_addr = a2;
        es_allowin   = esa;
        flush        = fl;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0;
        fwd_we    = '0;
        fwd_ready = '1;
        fwd_dest  = '0;
        fwd_data  = '0;
    endtask

    initial begin
        resetn = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        clear_fwd();
        for (int r = 0; r < 32; r++) rf_mem[r] = $urandom;
        rf_mem[5] = 32'h11;
        rf_mem[6] = 32'h22;
        reset_model();
        #12;
        checkOutput("rst_allowin", 64'(ds_allowin), 64'd1);
        checkOutput("rst_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        checkOutput("rst_payload", out_payload, 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Load-use on src2: two stall cycles, then the loaded value arrives.
        applyStimulus(1'b1, 64'hC0DE_0001, 1'b0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
        check_cycle();
        advance();
        in_valid  = 1'b0;
        fwd_valid = 3'b001;
        fwd_we    = 3'b001;
        fwd_dest[0 +: AW] = 5'd9;
        fwd_ready = 3'b110;
        for (int k = 0; k < 2; k++) begin
            check_cycle();
            checkOutput("lu_valid_low", 64'(ds_to_es_valid), 64'd0);
            checkOutput("lu_allowin_low", 64'(ds_allowin), 64'd0);
            advance();
        end
        fwd_ready = 3'b111;
        fwd_data[0 +: XLEN] = 32'h1234;
        check_cycle();
        checkOutput("lu_src2", 64'(out_src2), 64'h1234);
        checkOutput("lu_valid", 64'(ds_to_es_valid), 64'd1);
`ifdef DS_STALL_CNT_EN
        checkOutput("lu_stall_cnt", 64'(stall_cnt), 64'd2);
`endif
        advance();

        // No hazard: register file values flow through after one cycle.
        clear_fwd();
        applyStimulus(1'b1, 64'hC0DE_0002, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
        check_cycle();
        advance();
        in_valid = 1'b0;
        check_cycle();
        checkOutput("nh_src1", 64'(out_src1), 64'h11);
        checkOutput("nh_src2", 64'(out_src2), 64'h22);
        checkOutput("nh_valid", 64'(ds_to_es_valid), 64'd1);
        advance();

        // EX slot beats WB slot for the same destination.
        fwd_valid = 3'b101;
        fwd_we    = 3'b111;
        fwd_dest[0*AW +: AW] = 5'd7;
        fwd_dest[2*AW +: AW] = 5'd7;
        fwd_data[0*XLEN +: XLEN] = 32'hAAAA;
        fwd_data[2*XLEN +: XLEN] = 32'hBBBB;
        applyStimulus(1'b1, 64'hC0DE_0003, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0);
        check_cycle();
        advance();
        in_valid = 1'b0;
        check_cycle();
        checkOutput("ex_prio_src1", 64'(out_src1), 64'hAAAA);
        advance();

        // r0 never matches a producer, even a not-ready one.
        clear_fwd();
        fwd_valid = 3'b001;
        fwd_we    = 3'b001;
        fwd_ready = 3'b110;
        fwd_data[0 +: XLEN] = 32'hFFFF;
        applyStimulus(1'b1, 64'hC0DE_0004, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        check_cycle();
        advance();
        in_valid = 1'b0;
        check_cycle();
        checkOutput("r0_src1", 64'(out_src1), 64'd0);
        checkOutput("r0_valid", 64'(ds_to_es_valid), 64'd1);
        advance();

        // Flush while stalled: the instruction must never be presented.
        clear_fwd();
        applyStimulus(1'b1, 64'hC0DE_0005, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 1'b0);
        check_cycle();
        advance();
        in_valid  = 1'b0;
        fwd_valid = 3'b001;
        fwd_we    = 3'b001;
        fwd_dest[0 +: AW] = 5'd3;
        fwd_ready = 3'b110;
        check_cycle();
        checkOutput("fl_stalled", 64'(ds_to_es_valid), 64'd0);
        advance();
        flush     = 1'b1;
        fwd_ready = 3'b111;
        check_cycle();
        checkOutput("fl_no_out", 64'(ds_to_es_valid), 64'd0);
        advance();
        flush = 1'b0;
        clear_fwd();
        check_cycle();
        checkOutput("fl_allowin", 64'(ds_allowin), 64'd1);
        checkOutput("fl_valid", 64'(ds_to_es_valid), 64'd0);
        advance();

        // Asynchronous reset between edges while an instruction is held.
        applyStimulus(1'b1, 64'hC0DE_0006, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0);
        check_cycle();
        advance();
        in_valid = 1'b0;
        check_cycle();
        checkOutput("ar_before", 64'(ds_to_es_valid), 64'd1);
        #1 resetn = 1'b0;
        #1;
        checkOutput("ar_valid_low", 64'(ds_to_es_valid), 64'd0);
        checkOutput("ar_allowin", 64'(ds_allowin), 64'd1);
        reset_model();
        resetn = 1'b1;
        applyStimulus(1'b1, 64'hC0DE_0007, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0);
        cur_stall = 1'b0;
        cur_allow = 1'b1;
        cur_p1    = 1'b0;
        cur_p2    = 1'b0;
        advance();
        in_valid = 1'b0;
        check_cycle();
        checkOutput("ar_recapture", 64'(ds_to_es_valid), 64'd1);
        checkOutput("ar_src1", 64'(out_src1), 64'h11);
        advance();

        // Random traffic with small address range so hazards are frequent.
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom},
                          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
            for (int i = 0; i < NFWD; i++) begin
                fwd_valid[i] = $urandom_range(0, 3) != 0;
                fwd_we[i]    = $urandom_range(0, 3) != 0;
                fwd_ready[i] = $urandom_range(0, 4) != 0;
                fwd_dest[i*AW +: AW]     = AW'($urandom_range(0, 7));
                fwd_data[i*XLEN +: XLEN] = $urandom;
            end
            check_cycle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
